// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_pkg
//  Description : Shared types and constants for the vector issue path.
//                VLENB          - vector register length in bytes (one
//                                 register equals one datapath beat)
//                MAX_LMUL_LOG2  - largest register-group size, as log2
//                sew_t          - element-width encoding
//                seq_state_t    - issue sequencer state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package vector_pkg;

    localparam int VLENB         = 4;
    localparam int MAX_LMUL_LOG2 = 3;

    typedef enum logic [1:0] {
        SEW8        = 2'd0,
        SEW16       = 2'd1,
        SEW32       = 2'd2,
        SEW_ILLEGAL = 2'd3
    } sew_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/vector_byte_en_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vector_byte_en_gen
//  Description : Combinational beat geometry. From the count of elements
//                still to process and the element width, derives how many
//                elements the current register beat carries, which byte
//                lanes they occupy, and whether this is the final beat.
//  Ports       : remaining - elements left in the command (in)
//                vsew      - element width code (in)
//                active    - elements carried by this beat (out)
//                byte_en   - active byte lanes, low bits first (out)
//                last      - this beat exhausts the remaining count (out)
//  Revision    : 1.0  initial release
// ============================================================================
module vector_byte_en_gen
    import vector_pkg::*;
#(
    parameter int VLENB = vector_pkg::VLENB,
    parameter int REM_W = 6
) (
    input  logic [REM_W-1:0] remaining,
    input  sew_t             vsew,
    output logic [REM_W-1:0] active,
    output logic [VLENB-1:0] byte_en,
    output logic             last
);

    logic [1:0]       w_sew_code;
    logic [REM_W-1:0] w_per_reg;
    logic [REM_W-1:0] w_bytes;

    assign w_sew_code = vsew;

    // Elements that fit in one register; an illegal width carries nothing.
    assign w_per_reg = (vsew == SEW_ILLEGAL) ? '0 : (REM_W'(VLENB) >> w_sew_code);

    assign active  = (remaining < w_per_reg) ? remaining : w_per_reg;
    assign w_bytes = active << w_sew_code;
    assign last    = (remaining <= w_per_reg);

    // Active elements are packed from lane 0 upward, so the enable is a
    // thermometer code of the active byte count.
    generate
        for (genvar i = 0; i < VLENB; i++) begin : g_lane
            assign byte_en[i] = (w_bytes > REM_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vector_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vector_issue_sequencer
//  Description : Walks one vector instruction across its register group,
//                emitting one datapath beat per physical register with an
//                active-byte mask. The group size is set by vl, vsew and
//                vlmul; vl is silently clamped to the group capacity and
//                issue stops as soon as the active elements run out.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                flush             - abandon current command, back to IDLE
//                cmd_valid/ready   - command handshake
//                cmd_vl/vsew/vlmul - vector CSR snapshot
//                cmd_vd/vs1/vs2    - base register specifiers
//                beat_valid/ready  - beat handshake toward the datapath
//                beat_vd/vs1/vs2   - per-beat register addresses (mod 32)
//                beat_elem_base    - index of first element in the beat
//                beat_byte_en      - active byte lanes
//                beat_last         - final beat of the command
//                busy              - sequencer not idle
//                done/err          - one-cycle completion pulse, err
//                                    qualifies it (illegal SEW)
//  Revision    : 1.0  initial release
// ============================================================================
module vector_issue_sequencer
    import vector_pkg::*;
#(
    parameter  int VLENB  = vector_pkg::VLENB,
    parameter  int MAX_VL = 32,
    localparam int c_VL_W = $clog2(MAX_VL + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [c_VL_W-1:0] cmd_vl,
    input  logic [1:0]        cmd_vsew,
    input  logic [1:0]        cmd_vlmul,
    input  logic [4:0]        cmd_vd,
    input  logic [4:0]        cmd_vs1,
    input  logic [4:0]        cmd_vs2,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [4:0]        beat_vd,
    output logic [4:0]        beat_vs1,
    output logic [4:0]        beat_vs2,
    output logic [4:0]        beat_elem_base,
    output logic [VLENB-1:0]  beat_byte_en,
    output logic              beat_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // ------------------------------------------------------------------
    // Registered command context
    // ------------------------------------------------------------------
    seq_state_t               r_state;
    logic [4:0]               r_vd;
    logic [4:0]               r_vs1;
    logic [4:0]               r_vs2;
    sew_t                     r_vsew;
    logic [MAX_LMUL_LOG2-1:0] r_reg_idx;
    logic [4:0]               r_elem_base;
    logic [c_VL_W-1:0]        r_remaining;
    logic                     r_err;

    logic                     w_cmd_fire;
    logic [c_VL_W-1:0]        w_cmd_per_reg;
    logic [c_VL_W-1:0]        w_cmd_max_vl;
    logic [c_VL_W-1:0]        w_cmd_eff_vl;
    logic [c_VL_W-1:0]        w_active;
    logic [VLENB-1:0]         w_byte_en;
    logic                     w_last;
    logic                     w_issue;

    // ------------------------------------------------------------------
    // Incoming command geometry. An illegal SEW shifts per_reg to zero,
    // but that command is routed straight to DONE so the value is unused.
    // ------------------------------------------------------------------
    assign w_cmd_fire    = cmd_valid && (r_state == IDLE) && !flush;
    assign w_cmd_per_reg = c_VL_W'(VLENB) >> cmd_vsew;
    assign w_cmd_max_vl  = w_cmd_per_reg << cmd_vlmul;
    assign w_cmd_eff_vl  = (cmd_vl < w_cmd_max_vl) ? cmd_vl : w_cmd_max_vl;

    // ------------------------------------------------------------------
    // Current-beat geometry from the captured context
    // ------------------------------------------------------------------
    vector_byte_en_gen #(
        .VLENB (VLENB),
        .REM_W (c_VL_W)
    ) u_byte_en_gen (
        .remaining (r_remaining),
        .vsew      (r_vsew),
        .active    (w_active),
        .byte_en   (w_byte_en),
        .last      (w_last)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_vd        <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
            r_vsew      <= SEW8;
            r_reg_idx   <= '0;
            r_elem_base <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_vd        <= cmd_vd;
                        r_vs1       <= cmd_vs1;
                        r_vs2       <= cmd_vs2;
                        r_vsew      <= sew_t'(cmd_vsew);
                        r_reg_idx   <= '0;
                        r_elem_base <= '0;
                        r_remaining <= w_cmd_eff_vl;
                        r_err       <= (cmd_vsew == SEW_ILLEGAL);
                        if (cmd_vsew == SEW_ILLEGAL || w_cmd_eff_vl == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (beat_ready) begin
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            // A non-final beat is always a full register.
                            r_reg_idx   <= r_reg_idx + MAX_LMUL_LOG2'(1);
                            r_elem_base <= r_elem_base + 5'(w_active);
                            r_remaining <= r_remaining - w_active;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state. Beat fields are forced
    // to zero outside ISSUE so idle/reset outputs are clean.
    // ------------------------------------------------------------------
    assign w_issue        = (r_state == ISSUE);
    assign cmd_ready      = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign err            = (r_state == DONE) && r_err;
    assign beat_valid     = w_issue;
    assign beat_vd        = w_issue ? (r_vd  + 5'(r_reg_idx)) : '0;
    assign beat_vs1       = w_issue ? (r_vs1 + 5'(r_reg_idx)) : '0;
    assign beat_vs2       = w_issue ? (r_vs2 + 5'(r_reg_idx)) : '0;
    assign beat_elem_base = w_issue ? r_elem_base : '0;
    assign beat_byte_en   = w_issue ? w_byte_en : '0;
    assign beat_last      = w_issue && w_last;

endmodule
`default_nettype wire

// File: tb/tb_vector_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_issue_sequencer
//  Description : Self-checking bench for vector_issue_sequencer. Expected
//                beats are generated element by element from the command
//                and queued when the command is offered; each accepted beat
//                and each done pulse is popped and compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_issue_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_vl;
    logic [1:0] cmd_vsew;
    logic [1:0] cmd_vlmul;
    logic [4:0] cmd_vd;
    logic [4:0] cmd_vs1;
    logic [4:0] cmd_vs2;
    logic       beat_valid;
    logic       beat_ready;
    logic [4:0] beat_vd;
    logic [4:0] beat_vs1;
    logic [4:0] beat_vs2;
    logic [4:0] beat_elem_base;
    logic [3:0] beat_byte_en;
    logic       beat_last;
    logic       busy;
    logic       done;
    logic       err;

    vector_issue_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_vl         (cmd_vl),
        .cmd_vsew       (cmd_vsew),
        .cmd_vlmul      (cmd_vlmul),
        .cmd_vd         (cmd_vd),
        .cmd_vs1        (cmd_vs1),
        .cmd_vs2        (cmd_vs2),
        .beat_valid     (beat_valid),
        .beat_ready     (beat_ready),
        .beat_vd        (beat_vd),
        .beat_vs1       (beat_vs1),
        .beat_vs2       (beat_vs2),
        .beat_elem_base (beat_elem_base),
        .beat_byte_en   (beat_byte_en),
        .beat_last      (beat_last),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [4:0] base;
        logic [3:0] en;
        logic       last;
    } beat_t;

    typedef struct {
        int vl;
        int sew;
        int lmul;
        int vd;
        int vs1;
        int vs2;
        int beats;
    } vec_t;

    beat_t exp_q[$];
    logic  exp_err_q[$];
    int    n_tests   = 0;
    int    n_fail    = 0;
    int    beat_cnt  = 0;
    int    done_cnt  = 0;
    logic  hs        = 1'b0;
    logic  held_v    = 1'b0;
    logic  rand_rdy  = 1'b0;
    beat_t held;
    vec_t  tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.vd   = beat_vd;
        b.vs1  = beat_vs1;
        b.vs2  = beat_vs2;
        b.base = beat_elem_base;
        b.en   = beat_byte_en;
        b.last = beat_last;
        return b;
    endfunction

    // Reference: builds each beat from its individual elements.
    function automatic int push_model(input int vl, input int sew, input int lmul,
                                      input int vd, input int vs1, input int vs2);
        int    per;
        int    bpe;
        int    maxvl;
        int    eff;
        int    nb;
        beat_t b;
        if (sew == 3) begin
            exp_err_q.push_back(1'b1);
            return 0;
        end
        per   = 4 >> sew;
        bpe   = 1 << sew;
        maxvl = per << lmul;
        eff   = (vl < maxvl) ? vl : maxvl;
        nb    = (eff + per - 1) / per;
        for (int k = 0; k < nb; k++) begin
            b      = '0;
            b.vd   = 5'((vd  + k) % 32);
            b.vs1  = 5'((vs1 + k) % 32);
            b.vs2  = 5'((vs2 + k) % 32);
            b.base = 5'(k * per);
            for (int e = k * per; e < eff && e < (k + 1) * per; e++)
                for (int j = 0; j < bpe; j++)
                    b.en[(e - k * per) * bpe + j] = 1'b1;
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
        exp_err_q.push_back(1'b0);
        return nb;
    endfunction

    // One clock: sample at the falling edge, score, then step past the
    // rising edge.
    task automatic tick();
        beat_t b;
        beat_t e;
        @(negedge clk);
        b  = cur_beat();
        hs = cmd_valid && cmd_ready && !flush && !reset;
        if (!flush && !reset) begin
            if (held_v)
                check("stall_hold", {6'd0, beat_valid, b}, {6'd0, 1'b1, held});
            held_v = beat_valid && !beat_ready;
            held   = b;
            if (beat_valid && beat_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 32'(beat_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'(b), 32'(e));
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_err_q.size() == 0)
                    check("done_unexpected", 32'(done), 32'd0);
                else
                    check("done_err", 32'(err), 32'(exp_err_q.pop_front()));
            end
        end else begin
            held_v = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rand_rdy) beat_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_cmd(input int vl, input int sew, input int lmul,
                             input int vd, input int vs1, input int vs2);
        cmd_vl    = 6'(vl);
        cmd_vsew  = 2'(sew);
        cmd_vlmul = 2'(lmul);
        cmd_vd    = 5'(vd);
        cmd_vs1   = 5'(vs1);
        cmd_vs2   = 5'(vs2);
        cmd_valid = 1'b1;
    endtask

    // Scramble command inputs after acceptance; the captured copy must rule.
    task automatic scramble_cmd();
        cmd_valid = 1'b0;
        cmd_vl    = 6'($urandom);
        cmd_vsew  = 2'($urandom);
        cmd_vlmul = 2'($urandom);
        cmd_vd    = 5'($urandom);
        cmd_vs1   = 5'($urandom);
        cmd_vs2   = 5'($urandom);
    endtask

    task automatic run_cmd(input vec_t v);
        int nb;
        int d0;
        nb       = push_model(v.vl, v.sew, v.lmul, v.vd, v.vs1, v.vs2);
        beat_cnt = 0;
        d0       = done_cnt;
        drive_cmd(v.vl, v.sew, v.lmul, v.vd, v.vs1, v.vs2);
        hs = 1'b0;
        for (int i = 0; i < 10 && !hs; i++) tick();
        scramble_cmd();
        check("cmd_accepted", 32'(hs), 32'd1);
        for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("beat_count", 32'(beat_cnt), 32'(v.beats));
        check("queue_drained", 32'(exp_q.size() + exp_err_q.size()), 32'd0);
        if (nb != v.beats) check("table_entry_geometry", 32'(nb), 32'(v.beats));
        exp_q.delete();
        exp_err_q.delete();
    endtask

    // Scenario 2 driven into its second beat, then abandoned by flush or reset.
    task automatic abort_in_beat2(input logic use_reset);
        int d0;
        int nb;
        beat_ready = 1'b1;
        nb = push_model(8, 1, 2, 4, 6, 10);
        d0 = done_cnt;
        drive_cmd(8, 1, 2, 4, 6, 10);
        tick();
        scramble_cmd();
        tick();
        check("abort_in_beat2", {27'd0, beat_valid, beat_elem_base}, {27'd0, 1'b1, 5'd2});
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        check("abort_idle", {29'd0, beat_valid, cmd_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
        exp_q.delete();
        exp_err_q.delete();
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'(nb - nb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int nb;

        tbl[0]  = '{vl: 6,  sew: 0, lmul: 1, vd: 8,  vs1: 2,  vs2: 4,  beats: 2};
        tbl[1]  = '{vl: 8,  sew: 1, lmul: 2, vd: 0,  vs1: 1,  vs2: 2,  beats: 4};
        tbl[2]  = '{vl: 0,  sew: 0, lmul: 0, vd: 3,  vs1: 3,  vs2: 3,  beats: 0};
        tbl[3]  = '{vl: 4,  sew: 3, lmul: 1, vd: 5,  vs1: 6,  vs2: 7,  beats: 0};
        tbl[4]  = '{vl: 2,  sew: 2, lmul: 1, vd: 31, vs1: 30, vs2: 29, beats: 2};
        tbl[5]  = '{vl: 20, sew: 0, lmul: 2, vd: 16, vs1: 20, vs2: 24, beats: 4};
        tbl[6]  = '{vl: 32, sew: 0, lmul: 3, vd: 24, vs1: 8,  vs2: 0,  beats: 8};
        tbl[7]  = '{vl: 32, sew: 2, lmul: 3, vd: 8,  vs1: 16, vs2: 28, beats: 8};
        tbl[8]  = '{vl: 3,  sew: 1, lmul: 3, vd: 12, vs1: 13, vs2: 14, beats: 2};
        tbl[9]  = '{vl: 1,  sew: 2, lmul: 0, vd: 7,  vs1: 9,  vs2: 11, beats: 1};
        tbl[10] = '{vl: 5,  sew: 0, lmul: 3, vd: 30, vs1: 29, vs2: 31, beats: 2};

        reset      = 1'b1;
        flush      = 1'b0;
        cmd_valid  = 1'b0;
        beat_ready = 1'b0;
        cmd_vl     = '0;
        cmd_vsew   = '0;
        cmd_vlmul  = '0;
        cmd_vd     = '0;
        cmd_vs1    = '0;
        cmd_vs2    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_outputs_zero",
              {beat_valid, beat_vd, beat_vs1, beat_vs2, beat_elem_base, beat_byte_en, beat_last, busy, done, err},
              32'd0);
        reset = 1'b0;
        tick();

        // Scenario 1 with exact cycle timing.
        beat_ready = 1'b1;
        nb = push_model(6, 0, 1, 8, 2, 4);
        d0 = done_cnt;
        drive_cmd(6, 0, 1, 8, 2, 4);
        tick();
        scramble_cmd();
        check("s1_accept", 32'(hs), 32'd1);
        check("s1_beat0", {beat_valid, beat_vd, beat_elem_base, beat_byte_en, beat_last},
              {1'b1, 5'd8, 5'd0, 4'b1111, 1'b0});
        tick();
        check("s1_beat1", {beat_valid, beat_vd, beat_vs1, beat_vs2, beat_elem_base, beat_byte_en, beat_last},
              {1'b1, 5'd9, 5'd3, 5'd5, 5'd4, 4'b0011, 1'b1});
        tick();
        check("s1_done", {27'd0, done, err, beat_valid, cmd_ready, busy}, {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        check("s1_idle", {29'd0, cmd_ready, done, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("s1_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Scenario 3: zero vl and illegal SEW finish the cycle after accept.
        nb = push_model(0, 0, 0, 1, 1, 1);
        drive_cmd(0, 0, 0, 1, 1, 1);
        tick();
        scramble_cmd();
        check("vl0_done", {29'd0, done, err, beat_valid}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        nb = push_model(4, 3, 1, 1, 1, 1);
        drive_cmd(4, 3, 1, 1, 1, 1);
        tick();
        scramble_cmd();
        check("sew3_done", {29'd0, done, err, beat_valid}, {29'd0, 1'b1, 1'b1, 1'b0});
        tick();
        check("sew3_err_clears", {30'd0, err, cmd_ready}, {30'd0, 1'b0, 1'b1});

        // Scenario 2 with a three-cycle stall on the first beat.
        beat_ready = 1'b0;
        beat_cnt   = 0;
        d0 = done_cnt;
        nb = push_model(8, 1, 2, 0, 1, 2);
        drive_cmd(8, 1, 2, 0, 1, 2);
        tick();
        scramble_cmd();
        repeat (3) tick();
        beat_ready = 1'b1;
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        check("stall_beats", 32'(beat_cnt), 32'(nb));
        check("stall_done", 32'(done_cnt - d0), 32'd1);
        tick();

        // Scenario 6: flush, then reset, during the second beat.
        abort_in_beat2(1'b0);
        run_cmd(tbl[0]);
        abort_in_beat2(1'b1);
        run_cmd(tbl[0]);

        // Table sweep under random backpressure.
        rand_rdy = 1'b1;
        foreach (tbl[i]) run_cmd(tbl[i]);
        rand_rdy   = 1'b0;
        beat_ready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vector_issue_sequencer.md
Name: vector_issue_sequencer

Overview:
- Sequences one vector instruction across the register group selected by vl, vsew and vlmul.
- Emits one 32-bit datapath beat per physical register, with an active-byte mask.
- Sits between the decode/APU interface, which supplies the vector CSR snapshot and register specifiers, and the vector ALU/register-file datapath, which consumes the beats.
- Handles stalls, early termination when vl is exhausted, illegal SEW, and flush.

Parameters:
- VLENB, 4, vector register length in bytes; one register is one datapath beat.
- MAX_VL, 32, upper bound on vl, equal to VLENB*8 at 8-bit SEW and LMUL=8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abandons the current command; sequencer returns to IDLE
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_vl  in  6  requested vector length, 0..32
- cmd_vsew  in  2  SEW code: 0=8b, 1=16b, 2=32b, 3=illegal
- cmd_vlmul  in  2  LMUL log2: 1/2/4/8 registers
- cmd_vd  in  5  destination base register
- cmd_vs1  in  5  source 1 base register
- cmd_vs2  in  5  source 2 base register
- beat_valid  out  1  beat offered to the datapath
- beat_ready  in  1  datapath accepts the beat
- beat_vd  out  5  cmd_vd + reg_idx, mod 32
- beat_vs1  out  5  cmd_vs1 + reg_idx, mod 32
- beat_vs2  out  5  cmd_vs2 + reg_idx, mod 32
- beat_elem_base  out  5  index of the first element in this beat
- beat_byte_en  out  4  active byte lanes
- beat_last  out  1  final beat of the command
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; illegal SEW

Behaviour:
Reset and idle outputs:
- On reset, state=IDLE.
- All outputs are 0 except cmd_ready=1.
- Reset has priority over flush, which has priority over everything else.

Per-register geometry:
- per_reg = VLENB >> vsew, giving 4/2/1 elements.
- bytes_per_elem = 1 << vsew.
- max_vl = per_reg << vlmul.
- eff_vl = min(cmd_vl, max_vl); the clamp is silent.

Command capture:
- cmd_vl, cmd_vsew, cmd_vlmul and the three base registers are captured on the cmd_valid && cmd_ready handshake.
- Captured values are held for the whole command; later cmd_* changes have no effect.

FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - cmd_ready=1.
  - On handshake with vsew==3: go to DONE with err latched to 1.
  - On handshake with eff_vl==0: go to DONE with err=0.
  - Otherwise: go to ISSUE with reg_idx=0, elem_base=0, remaining=eff_vl.
- ISSUE:
  - cmd_ready=0, beat_valid=1.
  - active = min(per_reg, remaining).
  - beat_byte_en has the low (active*bytes_per_elem) bits set.
  - beat_last = (remaining <= per_reg).
  - On beat_ready:
    - If beat_last, go to DONE.
    - Otherwise reg_idx++, elem_base += per_reg, remaining -= per_reg.
  - With beat_valid high and beat_ready low, every beat_* output is held stable.
- DONE:
  - done=1 for exactly one cycle; err is valid in the same cycle.
  - Next state is IDLE. cmd_ready=0 in DONE.

Timing and counts:
- Command accepted in cycle N: first beat_valid in N+1.
- Last beat handshake in cycle M: done in M+1, cmd_ready in M+2.
- Beats per command = ceil(eff_vl/per_reg), which is at most 1 << vlmul.
- Registers past the last active element are never issued.

Register arithmetic and flags:
- Register addresses wrap modulo 32.
- Group alignment is not checked here; decode owns that check.
- busy=1 in ISSUE and DONE.

Flush:
- Flush in any state: next state is IDLE, beat_valid=0, no done pulse.
- A cmd_valid coinciding with flush is not accepted.

Decomposition:
- Shared package vector_pkg holds:
  - VLENB
  - the sew_t enum (SEW8, SEW16, SEW32, SEW_ILLEGAL)
  - the seq_state_t enum (IDLE, ISSUE, DONE)
  - a helper constant for the maximum LMUL log2
- One combinational sub-module, vector_byte_en_gen:
  - Inputs: remaining, vsew.
  - Outputs: active count, byte_en, last.
  - Reused later by the load/store unit.

Test Plan:
1. vsew=0, vlmul=1, vl=6, vd=8, vs1=2, vs2=4, beat_ready=1 -> 2 beats:
   - (vd8, vs1 2, vs2 4, base 0, en 1111, last 0)
   - (vd9, vs1 3, vs2 5, base 4, en 0011, last 1)
   - done=1, err=0 the cycle after the second beat.
2. vsew=1, vlmul=2, vl=8; beat_ready held low for 3 cycles on beat 1 -> 4 beats, each en 1111, elem_base 0/2/4/6; beat 1 outputs constant through the stall.
3. vl=0 accepted in cycle N -> no beat_valid, done=1 in N+1, err=0. Same with vsew=3, vl=4 -> done=1, err=1, no beats.
4. vsew=2, vlmul=1, vl=2, vd=31 -> beat_vd 31 then 0; elem_base 0 then 1; en 1111 both.
5. vsew=0, vlmul=2, vl=20 -> clamp to 16: 4 beats, en all 1111, last on beat 4.
6. Flush (and separately reset) asserted during the second beat of scenario 2 -> beat_valid=0 and cmd_ready=1 next cycle, no done. The next command then executes normally.
